aes_secure_access_arbiter: RTL
==============================

Name: aes_secure_access_arbiter

Overview:
- Multi-agent, token-checked front end for one AES-128 core.
- Arbitrates round-robin among NUM_AGENTS requesters and validates each agent's token against a per-agent expected token; only valid requests start the core.
- Locks out agents after repeated invalid attempts.
- Watches the core's start/done timing and flags anomalous completion (early, late, spurious), i.e. runtime Trojan detection.
- Sits between the SoC agents and the AES core inside system_on_chip.

Parameters:
- NUM_AGENTS, 4, number of requesting agents (2..8)
- TOKEN_W, 2, token width in bits
- DATA_W, 128, plaintext/key/ciphertext width
- MAX_FAIL, 3, consecutive invalid attempts before lockout
- LOCKOUT_CYCLES, 64, lockout duration in clk cycles
- CORE_LATENCY, 22, nominal cycles from core_start to core_done
- LATENCY_SLACK, 2, allowed +/- deviation from CORE_LATENCY
- HALT_ON_ANOMALY, 1, 1 = stop granting once anomaly is set

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req  in  NUM_AGENTS  level request per agent
- agent_token  in  NUM_AGENTS*TOKEN_W  presented token, agent i at [i*TOKEN_W +: TOKEN_W]
- exp_token  in  NUM_AGENTS*TOKEN_W  static expected token per agent
- plaintext  in  NUM_AGENTS*DATA_W  per-agent plaintext
- key  in  NUM_AGENTS*DATA_W  per-agent key
- ack  out  NUM_AGENTS  1-cycle pulse, request accepted and core started
- deny  out  NUM_AGENTS  1-cycle pulse, token mismatch
- locked  out  NUM_AGENTS  agent in lockout
- core_start  out  1  1-cycle start to AES core
- core_pt  out  DATA_W  plaintext to core, stable from core_start until core_done
- core_key  out  DATA_W  key to core, same stability
- core_busy  in  1  core busy; informational, and its rise enables the start-acknowledge check
- core_done  in  1  core completion pulse
- core_ct  in  DATA_W  core ciphertext, valid with core_done
- ct_out  out  DATA_W  registered ciphertext
- ct_valid  out  1  1-cycle pulse with ct_out
- ct_agent  out  $clog2(NUM_AGENTS)  owner of ct_out
- done_latched  out  NUM_AGENTS  sticky per-agent completion
- done_clr  in  NUM_AGENTS  clears done_latched[i]
- anomaly  out  1  sticky timing anomaly
- anomaly_code  out  2  00 none, 01 early, 10 late/timeout, 11 spurious done

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0.
  - FSM goes to IDLE, round-robin pointer to 0, fail counters and lockout timers to 0.
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE: eligible = req & ~locked (and ~anomaly if HALT_ON_ANOMALY).
  - Winner is the first eligible index at or after rr_ptr, wrapping.
  - Winner index is registered, then the FSM goes to CHECK. Nothing happens if there is no eligible request.
- CHECK (1 cycle): compare agent_token[w] against exp_token[w].
  - Mismatch: deny[w]=1 next cycle; fail_cnt[w]++.
    - If fail_cnt reaches MAX_FAIL: locked[w]=1, lockout timer loaded with LOCKOUT_CYCLES, fail_cnt cleared.
    - rr_ptr=w+1 mod NUM_AGENTS; FSM returns to IDLE.
  - Match: fail_cnt[w]=0; capture plaintext[w] and key[w] into core_pt/core_key; FSM goes to ISSUE.
- ISSUE: core_start=1 and ack[w]=1 for exactly this cycle; cycle counter cleared; FSM goes to WAIT.
- WAIT: counter increments each cycle, with count 1 on the first WAIT cycle.
  - On core_done: capture core_ct. If count < CORE_LATENCY-LATENCY_SLACK, set anomaly with code 01; the ciphertext is still delivered. FSM goes to RESP.
  - If count reaches CORE_LATENCY+LATENCY_SLACK with no done: anomaly code 10, no ct_valid, FSM goes to IDLE.
  - If core_busy never rose by count 2: anomaly code 10, FSM aborts to IDLE.
- RESP: ct_valid=1, ct_agent=w, ct_out=captured value; done_latched[w] is set; rr_ptr=w+1; FSM goes to IDLE.
- Spurious done: core_done=1 in IDLE, CHECK or ISSUE sets anomaly with code 11.
- Anomaly codes: only the first anomaly code is retained. anomaly clears only on reset.
- Lockout timer: decrements each cycle; locked[i] drops the cycle the timer reaches 0.
  - A req from a locked agent is ignored, with no deny and no fail count.
- done_clr[i] clears done_latched[i] the next cycle. A simultaneous set (RESP for i) wins.
- A req held high after ack or deny is re-arbitrated normally. Fairness comes from the rr_ptr advance.
- Token inputs are sampled only in CHECK. Token changes at other times have no effect.
- Reset mid-WAIT: aborts immediately with no ct_valid. A late core_done after reset flags anomaly code 11.
- Nominal latency: req seen in IDLE at cycle 0, then CHECK at 1, core_start at 2, core_done at 2+CORE_LATENCY, ct_valid one cycle later.

Decomposition:
- Package aes_arb_pkg holds:
  - state_t enum {IDLE, CHECK, ISSUE, WAIT, RESP};
  - anomaly_code_t enum (NONE, EARLY, LATE, SPURIOUS);
  - localparams for widths, such as IDX_W=$clog2(NUM_AGENTS).
- Sub-module rr_picker (parametrised on NUM_AGENTS): combinational round-robin first-one-from-pointer select.
- Per-agent fail/lockout counters are a generate loop in the top module.

Test Plan:
- Valid single request: agent 1, exp_token=01, token=01, plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, behavioural core with latency 22.
  -> ack[1] at cycle 2, ct_valid with ct_out=69c4e0d86a7b0430d8cdb78070b4c55a and ct_agent=1, done_latched[1]=1, anomaly=0.
- Invalid token: agent 0 with token=00 against exp 10.
  -> deny[0] pulse, no core_start. After 3 attempts locked[0]=1 for 64 cycles; a 4th req is ignored; a valid req after the unlock is acked.
- Fairness: agents 0, 2 and 3 hold req high with valid tokens.
  -> grant order 0,2,3,0. done_clr[2] coinciding with agent 2's RESP leaves done_latched[2]=1.
- Early Trojan completion: core model asserts done at count 10.
  -> anomaly=1, code 01, ct still delivered. With HALT_ON_ANOMALY=1, subsequent reqs get neither ack nor deny.
- Timeout: core model never asserts done.
  -> at count 24 anomaly code 10, FSM back in IDLE, no ct_valid.
- Spurious done and reset: core_done pulsed in IDLE gives anomaly code 11. rst_n=0 during WAIT clears all outputs the next cycle with no ct_valid.

Source files
------------

// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared types and width helpers for the AES secure access arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package aes_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      NONE     = 2'b00,
      EARLY    = 2'b01,
      LATE     = 2'b10,
      SPURIOUS = 2'b11
   } anomaly_code_t;

   localparam int ANOMALY_W = 2;

   // Index width for an agent count; never below 1 bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold values 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin select, first set request at or after ptr (wrapping).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req (request vector), ptr (start index), vld (any request), idx (winner index).
module rr_picker
   import aes_arb_pkg::*;
#(
   parameter int NUM_AGENTS = 4
) (
   input  logic [NUM_AGENTS-1:0]        req,
   input  logic [idx_w(NUM_AGENTS)-1:0] ptr,
   output logic                         vld,
   output logic [idx_w(NUM_AGENTS)-1:0] idx
);

   localparam int IDX_W = idx_w(NUM_AGENTS);

   // Walk the offsets from the far end back toward ptr so the closest hit is written last.
   always_comb begin
      int j;
      j   = 0;
      vld = 1'b0;
      idx = '0;
      for (int k = NUM_AGENTS - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % NUM_AGENTS;
         if (req[j]) begin
            vld = 1'b1;
            idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/aes_secure_access_arbiter.sv
// aes_secure_access_arbiter: token-checked round-robin front end for one AES-128 core with timing watchdog.
// Latency: req seen in IDLE -> core_start/ack 2 cycles later; ct_valid 1 cycle after core_done.
// Backpressure: level req is held by the agent; locked or halted agents are simply never granted.
// Ports: req/agent_token/exp_token/plaintext/key per agent in; ack/deny/locked/done_latched per agent out;
//        core_start/core_pt/core_key to the core, core_busy/core_done/core_ct from it;
//        ct_out/ct_valid/ct_agent result; done_clr clears done_latched; anomaly/anomaly_code watchdog.
module aes_secure_access_arbiter
   import aes_arb_pkg::*;
#(
   parameter int NUM_AGENTS      = 4,
   parameter int TOKEN_W         = 2,
   parameter int DATA_W          = 128,
   parameter int MAX_FAIL        = 3,
   parameter int LOCKOUT_CYCLES  = 64,
   parameter int CORE_LATENCY    = 22,
   parameter int LATENCY_SLACK   = 2,
   parameter int HALT_ON_ANOMALY = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_AGENTS-1:0]         req,
   input  logic [NUM_AGENTS*TOKEN_W-1:0] agent_token,
   input  logic [NUM_AGENTS*TOKEN_W-1:0] exp_token,
   input  logic [NUM_AGENTS*DATA_W-1:0]  plaintext,
   input  logic [NUM_AGENTS*DATA_W-1:0]  key,
   output logic [NUM_AGENTS-1:0]         ack,
   output logic [NUM_AGENTS-1:0]         deny,
   output logic [NUM_AGENTS-1:0]         locked,
   output logic                          core_start,
   output logic [DATA_W-1:0]             core_pt,
   output logic [DATA_W-1:0]             core_key,
   input  logic                          core_busy,
   input  logic                          core_done,
   input  logic [DATA_W-1:0]             core_ct,
   output logic [DATA_W-1:0]             ct_out,
   output logic                          ct_valid,
   output logic [idx_w(NUM_AGENTS)-1:0]  ct_agent,
   output logic [NUM_AGENTS-1:0]         done_latched,
   input  logic [NUM_AGENTS-1:0]         done_clr,
   output logic                          anomaly,
   output logic [ANOMALY_W-1:0]          anomaly_code
);

   localparam int IDX_W  = idx_w(NUM_AGENTS);
   localparam int CNT_W  = cnt_w(CORE_LATENCY + LATENCY_SLACK);
   localparam int FAIL_W = cnt_w(MAX_FAIL);
   localparam int TMR_W  = cnt_w(LOCKOUT_CYCLES);

   localparam logic [CNT_W-1:0]  EARLY_LIM = CNT_W'(CORE_LATENCY - LATENCY_SLACK);
   localparam logic [CNT_W-1:0]  LATE_LIM  = CNT_W'(CORE_LATENCY + LATENCY_SLACK);
   localparam logic [CNT_W-1:0]  BUSY_LIM  = CNT_W'(2);
   localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
   localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_AGENTS - 1);

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        win_q, win_d, rr_q, rr_d, ct_agent_q, ct_agent_d;
   logic [DATA_W-1:0]       pt_q, pt_d, key_q, key_d, ct_q, ct_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d, wcnt;
   logic                    busy_seen_q, busy_seen_d;
   logic                    anomaly_q, anomaly_d;
   anomaly_code_t           code_q, code_d;
   logic [NUM_AGENTS-1:0]   deny_q, deny_d, done_q, done_d;
   logic [NUM_AGENTS-1:0]   locked_v, eligible, fail_ev, pass_ev;
   logic                    pick_vld, tok_ok, halt, an_set;
   logic [IDX_W-1:0]        pick_idx, win_nxt;
   anomaly_code_t           an_code;

   assign halt     = (HALT_ON_ANOMALY != 0) && anomaly_q;
   assign eligible = req & ~locked_v & {NUM_AGENTS{~halt}};
   assign tok_ok   = agent_token[int'(win_q)*TOKEN_W +: TOKEN_W] == exp_token[int'(win_q)*TOKEN_W +: TOKEN_W];
   assign win_nxt  = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
   // Count as seen by the WAIT cycle: 1 on the first WAIT cycle.
   assign wcnt     = cnt_q + CNT_W'(1);

   rr_picker #(.NUM_AGENTS(NUM_AGENTS)) u_pick (
      .req (eligible),
      .ptr (rr_q),
      .vld (pick_vld),
      .idx (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      rr_d        = rr_q;
      pt_d        = pt_q;
      key_d       = key_q;
      ct_d        = ct_q;
      ct_agent_d  = ct_agent_q;
      cnt_d       = cnt_q;
      busy_seen_d = busy_seen_q;
      deny_d      = '0;
      done_d      = done_q & ~done_clr;
      an_set      = 1'b0;
      an_code     = NONE;
      anomaly_d   = anomaly_q;
      code_d      = code_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               win_d   = pick_idx;
               state_d = CHECK;
            end
            if (core_done) begin
               an_set  = 1'b1;
               an_code = SPURIOUS;
            end
         end
         CHECK: begin
            if (tok_ok) begin
               pt_d    = plaintext[int'(win_q)*DATA_W +: DATA_W];
               key_d   = key[int'(win_q)*DATA_W +: DATA_W];
               state_d = ISSUE;
            end else begin
               deny_d[win_q] = 1'b1;
               rr_d          = win_nxt;
               state_d       = IDLE;
            end
            if (core_done) begin
               an_set  = 1'b1;
               an_code = SPURIOUS;
            end
         end
         ISSUE: begin
            cnt_d       = '0;
            busy_seen_d = 1'b0;
            state_d     = WAIT;
            if (core_done) begin
               an_set  = 1'b1;
               an_code = SPURIOUS;
            end
         end
         WAIT: begin
            cnt_d = wcnt;
            if (core_busy) busy_seen_d = 1'b1;
            if (core_done) begin
               // Early completion is flagged but the result is still handed back.
               ct_d       = core_ct;
               ct_agent_d = win_q;
               state_d    = RESP;
               if (wcnt < EARLY_LIM) begin
                  an_set  = 1'b1;
                  an_code = EARLY;
               end
            end else if (wcnt == LATE_LIM) begin
               an_set  = 1'b1;
               an_code = LATE;
               state_d = IDLE;
            end else if (wcnt == BUSY_LIM && !busy_seen_q && !core_busy) begin
               // Core never acknowledged the start: treat as a stalled core.
               an_set  = 1'b1;
               an_code = LATE;
               state_d = IDLE;
            end
         end
         RESP: begin
            done_d[win_q] = 1'b1;
            rr_d          = win_nxt;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Only the first anomaly is recorded.
      if (an_set && !anomaly_q) begin
         anomaly_d = 1'b1;
         code_d    = an_code;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         win_q       <= '0;
         rr_q        <= '0;
         pt_q        <= '0;
         key_q       <= '0;
         ct_q        <= '0;
         ct_agent_q  <= '0;
         cnt_q       <= '0;
         busy_seen_q <= 1'b0;
         anomaly_q   <= 1'b0;
         code_q      <= NONE;
         deny_q      <= '0;
         done_q      <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         rr_q        <= rr_d;
         pt_q        <= pt_d;
         key_q       <= key_d;
         ct_q        <= ct_d;
         ct_agent_q  <= ct_agent_d;
         cnt_q       <= cnt_d;
         busy_seen_q <= busy_seen_d;
         anomaly_q   <= anomaly_d;
         code_q      <= code_d;
         deny_q      <= deny_d;
         done_q      <= done_d;
      end
   end

   // Per-agent consecutive-failure counter and lockout timer.
   for (genvar i = 0; i < NUM_AGENTS; i++) begin : g_agent
      logic [FAIL_W-1:0] fail_q, fail_d;
      logic [TMR_W-1:0]  tmr_q, tmr_d;

      assign fail_ev[i] = (state_q == CHECK) && (win_q == IDX_W'(i)) && !tok_ok;
      assign pass_ev[i] = (state_q == CHECK) && (win_q == IDX_W'(i)) && tok_ok;

      always_comb begin
         fail_d = fail_q;
         tmr_d  = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
         if (fail_ev[i]) begin
            if (fail_q == FAIL_LAST) begin
               fail_d = '0;
               tmr_d  = LOCK_LOAD;
            end else begin
               fail_d = fail_q + FAIL_W'(1);
            end
         end else if (pass_ev[i]) begin
            fail_d = '0;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            fail_q <= '0;
            tmr_q  <= '0;
         end else begin
            fail_q <= fail_d;
            tmr_q  <= tmr_d;
         end
      end

      assign locked_v[i] = (tmr_q != '0);
   end

   assign ack          = (state_q == ISSUE) ? ({{(NUM_AGENTS-1){1'b0}}, 1'b1} << win_q) : '0;
   assign deny         = deny_q;
   assign locked       = locked_v;
   assign core_start   = (state_q == ISSUE);
   assign core_pt      = pt_q;
   assign core_key     = key_q;
   assign ct_out       = ct_q;
   assign ct_valid     = (state_q == RESP);
   assign ct_agent     = ct_agent_q;
   assign done_latched = done_q;
   assign anomaly      = anomaly_q;
   assign anomaly_code = code_q;

endmodule
